combination_lock_ctrl: RTL and testbench
========================================

Name: combination_lock_ctrl

Overview:
Session controller for a keypad combination lock. It holds a programmable code and frames each entry attempt with an inter-digit timeout. It compares the collected digits against the code, then drives a timed unlock pulse or records a failure. Repeated failures put the lock into a timed lockout. It sits between the raw zero/one keypad strobes and the door actuator and replaces the fixed-code detector for configurable deployments.

Parameters:
CODE_LEN, 5, digits per combination (1..16)
RESET_CODE, 5'b01011, code loaded at reset; the first digit is the MSB
MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)
TIMEOUT_CYCLES, 16, idle cycles allowed between digits before the entry is abandoned
UNLOCK_CYCLES, 8, cycles unlock stays high
LOCKOUT_CYCLES, 64, cycles locked_out stays high

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
zero  in  1  digit-0 strobe, sampled every cycle
one  in  1  digit-1 strobe, sampled every cycle
cfg_we  in  1  code write enable
cfg_code  in  CODE_LEN  new code value, taken when cfg_we is accepted
unlock  out  1  door release
locked_out  out  1  lockout active
busy  out  1  high in any state other than IDLE
fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failure count

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; code=RESET_CODE; digit count, shift register and timer =0; unlock=0; locked_out=0; busy=0; fail_cnt=0. All outputs are registered.
- Digit: a cycle where exactly one of zero/one is high. zero and one high together = invalid digit.
- IDLE:
  - Valid digit: shift it into the shift register (MSB first), set count=1, go to ENTRY.
  - Invalid digit: go to FAIL.
  - cfg_we: load cfg_code. cfg_we is accepted only in IDLE, ignored in every other state, and when it coincides with a digit the digit wins.
- ENTRY:
  - Valid digit: shift it in, count+1, restart the timer.
  - Invalid digit: go to FAIL.
  - count reaches CODE_LEN: go to CHECK.
  - TIMEOUT_CYCLES consecutive cycles without a digit: return to IDLE with no failure counted; shift register cleared.
- CHECK (1 cycle): shift register == code goes to OPEN, otherwise FAIL. Inputs are ignored.
- Latency: final digit sampled at edge t; CHECK runs in cycle t+1; unlock rises after edge t+2.
- OPEN: unlock=1 for exactly UNLOCK_CYCLES cycles; fail_cnt cleared on entry; digits are ignored; then IDLE.
- FAIL (1 cycle): fail_cnt increments, saturating at MAX_FAIL. Then:
  - fail_cnt == MAX_FAIL: go to LOCKOUT.
  - otherwise: go to IDLE.
- LOCKOUT: locked_out=1 for LOCKOUT_CYCLES cycles; digits and cfg_we are ignored. On exit, fail_cnt=0 and state=IDLE.
- Strobe handling: a digit held high for N cycles counts as N digits; debouncing is upstream.
- Reset asserted mid-OPEN or mid-LOCKOUT drops unlock/locked_out immediately.
- A code change takes effect on the next attempt.

Optional Feature:
COMB_LOCK_ALARM_EN:
- Defined: adds output port alarm (1 bit), reset 0. alarm pulses high for one cycle on each entry into LOCKOUT and stays low otherwise.
- Undefined: the alarm port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package combination_lock_pkg:
  - state enum (IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT)
  - width constants/functions for the timer, digit count and fail_cnt
- Sub-module lock_timer: loadable down-counter with a terminal-count flag, sized for max(TIMEOUT_CYCLES, UNLOCK_CYCLES, LOCKOUT_CYCLES). A single instance is shared, because ENTRY, OPEN and LOCKOUT are mutually exclusive.

Test Plan:
- Defaults, digits 0,1,0,1,1 on consecutive cycles -> unlock rises 2 cycles after the last digit, stays high 8 cycles, fail_cnt=0, then busy=0.
- Digits 0,1,1,1,1 three times -> fail_cnt 1,2,3; locked_out high 64 cycles; digits entered during lockout are ignored; fail_cnt=0 after exit.
- Digits 0,1 then 16 idle cycles -> back to IDLE, fail_cnt unchanged, no unlock; a fresh 01011 then unlocks.
- cfg_we=1 with cfg_code=5'b11100 in IDLE -> 01011 now fails and 11100 unlocks; cfg_we during ENTRY leaves the code unchanged.
- zero=one=1 during ENTRY -> FAIL, fail_cnt +1, no unlock.
- rst pulsed low mid-OPEN (cycle 3 of 8) -> unlock drops asynchronously, code returns to 01011; with COMB_LOCK_ALARM_EN defined, the third failure gives a 1-cycle alarm pulse.

Source files
------------

// File: rtl/combination_lock_pkg.sv
// combination_lock_pkg: state encoding and width helpers shared by the combination lock files
package combination_lock_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t ENTRY   = 3'd1;
  localparam state_t CHECK   = 3'd2;
  localparam state_t OPEN    = 3'd3;
  localparam state_t FAIL    = 3'd4;
  localparam state_t LOCKOUT = 3'd5;
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction
  function automatic int fc_w(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction
  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter; tc is high while the count sits at zero
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;
  // reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - W'(1);
  assign tc = count == '0;
endmodule

// File: rtl/combination_lock_ctrl.sv
// combination_lock_ctrl: programmable keypad lock session controller; define COMB_LOCK_ALARM_EN to add a one-cycle alarm pulse on lockout entry
module combination_lock_ctrl
  import combination_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] RESET_CODE     = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       zero,
  input  logic                       one,
  input  logic                       cfg_we,
  input  logic [CODE_LEN-1:0]        cfg_code,
  output logic                       unlock,
  output logic                       locked_out,
  output logic                       busy,
  output logic [fc_w(MAX_FAIL)-1:0]  fail_cnt
`ifdef COMB_LOCK_ALARM_EN
  ,
  output logic                       alarm
`endif
);
  localparam int CW = cnt_w(CODE_LEN);
  localparam int FW = fc_w(MAX_FAIL);
  localparam int TW = tmr_w(TIMEOUT_CYCLES, UNLOCK_CYCLES, LOCKOUT_CYCLES);
  state_t              st, nxt;
  logic [CODE_LEN-1:0] code, sr;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       fc_inc;
  logic [TW-1:0]       tmr_val;
  logic                vd, bad, full, tmr_load, tmr_tc;
  assign vd = zero ^ one;
  assign bad = zero & one;
  assign full = cnt == CW'(CODE_LEN);
  assign fc_inc = fail_cnt == FW'(MAX_FAIL) ? fail_cnt : fail_cnt + FW'(1);
  // one timer serves ENTRY, OPEN and LOCKOUT: reload on every state change and on each accepted digit
  assign tmr_load = (nxt != st) | (st == ENTRY & vd);
  assign tmr_val = nxt == OPEN ? TW'(UNLOCK_CYCLES - 1) :
                   nxt == LOCKOUT ? TW'(LOCKOUT_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);
  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );
  // next-state selection; a full entry is checked one cycle after its last digit
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = bad ? FAIL : vd ? ENTRY : IDLE;
      ENTRY:   nxt = full ? CHECK : bad ? FAIL : vd ? ENTRY : tmr_tc ? IDLE : ENTRY;
      CHECK:   nxt = sr == code ? OPEN : FAIL;
      OPEN:    nxt = tmr_tc ? IDLE : OPEN;
      FAIL:    nxt = fc_inc == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
      LOCKOUT: nxt = tmr_tc ? IDLE : LOCKOUT;
      default: nxt = IDLE;
    endcase
  end
  // state register and outputs registered from the next state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      unlock <= 1'b0;
      locked_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      unlock <= nxt == OPEN;
      locked_out <= nxt == LOCKOUT;
      busy <= nxt != IDLE;
    end
  // code is writable only from an idle lock with no strobe present
  always_ff @(posedge clk or negedge rst)
    if (!rst) code <= RESET_CODE;
    else if (st == IDLE && cfg_we && !zero && !one) code <= cfg_code;
  // collect digits MSB first; cleared whenever no entry is in progress
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (st == IDLE && vd) begin
      sr <= CODE_LEN'(one);
      cnt <= CW'(1);
    end else if (st == ENTRY && vd && !full) begin
      sr <= (sr << 1) | CODE_LEN'(one);
      cnt <= cnt + CW'(1);
    end else if (st != ENTRY || nxt == IDLE) begin
      sr <= '0;
      cnt <= '0;
    end
  // consecutive failures: saturating bump in FAIL, cleared on a successful open or when lockout ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) fail_cnt <= '0;
    else if (st == FAIL) fail_cnt <= fc_inc;
    else if ((st == CHECK && nxt == OPEN) || (st == LOCKOUT && nxt == IDLE)) fail_cnt <= '0;
`ifdef COMB_LOCK_ALARM_EN
  // single-cycle pulse marking each entry into lockout
  always_ff @(posedge clk or negedge rst)
    if (!rst) alarm <= 1'b0;
    else alarm <= nxt == LOCKOUT && st != LOCKOUT;
`endif
endmodule

// File: tb/tb_combination_lock_ctrl.sv
// tb_combination_lock_ctrl: randomized attempt-level checks against a per-attempt outcome model
module tb_combination_lock_ctrl;
  localparam int CL = 5;
  localparam logic [CL-1:0] RC = 5'b01011;
  localparam int MF = 3;
  localparam int TO = 16;
  localparam int UC = 8;
  localparam int LC = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zero = 1'b0;
  logic one = 1'b0;
  logic cfg_we = 1'b0;
  logic [CL-1:0] cfg_code = '0;
  logic unlock, locked_out, busy;
  logic [1:0] fail_cnt;
`ifdef COMB_LOCK_ALARM_EN
  logic alarm;
`endif
  int ncmp = 0;
  int nerr = 0;
  logic [CL-1:0] m_code = RC;
  int m_fails = 0;

  always #5 clk = ~clk;

  combination_lock_ctrl #(
    .CODE_LEN(CL), .RESET_CODE(RC), .MAX_FAIL(MF),
    .TIMEOUT_CYCLES(TO), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .zero       (zero),
    .one        (one),
    .cfg_we     (cfg_we),
    .cfg_code   (cfg_code),
    .unlock     (unlock),
    .locked_out (locked_out),
    .busy       (busy),
    .fail_cnt   (fail_cnt)
`ifdef COMB_LOCK_ALARM_EN
    ,
    .alarm      (alarm)
`endif
  );

  task automatic step(input logic z, input logic o, input logic w, input logic [CL-1:0] c);
    zero = z;
    one = o;
    cfg_we = w;
    cfg_code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_code(input logic [CL-1:0] v, input logic we);
    for (int j = CL - 1; j >= 0; j--) step(!v[j], v[j], we, CL'($urandom));
  endtask

  // kind 0: correct code opens; kind 1: failure with FAIL state at sample fail_at; kind 2: entry abandoned by timeout
  task automatic observe(input int kind, input int fail_at, input string tag);
    int e_first, e_un, e_lk, e_idle, e_mid, e_end, e_al, mid_at, jlo, jhi;
    int first, un, lk, idle, mid, fend, al;
    logic jk;
    first = -1; un = 0; lk = 0; idle = -1; mid = -1; fend = -1; al = 0;
    e_first = -1; e_un = 0; e_lk = 0; e_al = 0; jlo = 1; jhi = 0;
    e_idle = 0; e_mid = 0; e_end = 0; mid_at = 1;
    if (kind == 0) begin
      e_first = 2; e_un = UC; e_idle = 2 + UC; e_mid = 0; mid_at = 2; e_end = 0;
      m_fails = 0; jlo = 1; jhi = 1 + UC;
    end else if (kind == 1) begin
      m_fails = m_fails + 1 > MF ? MF : m_fails + 1;
      e_mid = m_fails; mid_at = fail_at + 1;
      if (m_fails == MF) begin
        e_lk = LC; e_idle = fail_at + 1 + LC; e_end = 0; e_al = 1;
        jlo = fail_at + 1; jhi = fail_at + LC; m_fails = 0;
      end else begin
        e_idle = fail_at + 1; e_end = m_fails;
      end
    end else begin
      e_idle = TO; e_mid = m_fails; mid_at = 1; e_end = m_fails;
    end
    for (int i = 1; i <= 200 && idle < 0; i++) begin
      jk = (i - 1 >= jlo && i - 1 <= jhi) || (kind == 1 && fail_at == 2 && i - 1 == 1);
      if (kind == 2) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), CL'($urandom));
      else if (jk) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CL'($urandom));
      else idle_step();
      if (unlock) begin
        un++;
        if (first < 0) first = i;
      end
      if (locked_out) lk++;
`ifdef COMB_LOCK_ALARM_EN
      if (alarm) al++;
`endif
      if (i == mid_at) mid = fail_cnt;
      if (!busy) begin
        idle = i;
        fend = fail_cnt;
      end
    end
    ncmp++; if (first !== e_first) begin nerr++; $display("FAIL %s unlock_rise got %0d want %0d", tag, first, e_first); end
    ncmp++; if (un !== e_un) begin nerr++; $display("FAIL %s unlock_cycles got %0d want %0d", tag, un, e_un); end
    ncmp++; if (lk !== e_lk) begin nerr++; $display("FAIL %s lockout_cycles got %0d want %0d", tag, lk, e_lk); end
    ncmp++; if (idle !== e_idle) begin nerr++; $display("FAIL %s idle_at got %0d want %0d", tag, idle, e_idle); end
    ncmp++; if (mid !== e_mid) begin nerr++; $display("FAIL %s fail_cnt_after_decision got %0d want %0d", tag, mid, e_mid); end
    ncmp++; if (fend !== e_end) begin nerr++; $display("FAIL %s fail_cnt_at_idle got %0d want %0d", tag, fend, e_end); end
`ifdef COMB_LOCK_ALARM_EN
    ncmp++; if (al !== e_al) begin nerr++; $display("FAIL %s alarm_pulses got %0d want %0d", tag, al, e_al); end
`endif
  endtask

  task automatic attempt(input logic [CL-1:0] v, input logic we, input string tag);
    send_code(v, we);
    observe(v == m_code ? 0 : 1, 2, tag);
  endtask

  task automatic invalid_at(input int p, input string tag);
    logic b;
    for (int j = 0; j < p; j++) begin
      b = 1'($urandom_range(0, 1));
      step(!b, b, 1'b0, '0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    observe(1, 0, tag);
  endtask

  task automatic timeout_after(input int p, input string tag);
    logic b;
    for (int j = 0; j < p; j++) begin
      b = 1'($urandom_range(0, 1));
      step(!b, b, 1'b0, '0);
    end
    observe(2, 0, tag);
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    ncmp++; if ({unlock, locked_out, busy, fail_cnt} !== 5'b0) begin nerr++; $display("FAIL reset_async outputs got %b want 00000", {unlock, locked_out, busy, fail_cnt}); end
    @(posedge clk);
    #1;
    ncmp++; if ({unlock, locked_out, busy, fail_cnt} !== 5'b0) begin nerr++; $display("FAIL reset_held outputs got %b want 00000", {unlock, locked_out, busy, fail_cnt}); end
`ifdef COMB_LOCK_ALARM_EN
    ncmp++; if (alarm !== 1'b0) begin nerr++; $display("FAIL reset_alarm got %b want 0", alarm); end
`endif
    rst = 1'b1;
    m_code = RC;
    m_fails = 0;
  endtask

  task automatic test_unlock();
    idle_step();
    attempt(RC, 1'b0, "unlock_default");
  endtask

  task automatic test_lockout();
    for (int n = 0; n < MF; n++) attempt(5'b01111, 1'b0, "lockout_seq");
  endtask

  task automatic test_timeout();
    attempt(5'b11111, 1'b0, "timeout_prefail");
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    observe(2, 0, "timeout_01");
    attempt(RC, 1'b0, "timeout_then_open");
  endtask

  task automatic test_invalid();
    invalid_at(2, "invalid_entry");
    invalid_at(0, "invalid_idle");
  endtask

  task automatic test_cfg();
    logic [CL-1:0] nc;
    nc = 5'b11100;
    step(1'b0, 1'b0, 1'b1, nc);
    m_code = nc;
    attempt(RC, 1'b0, "cfg_old_code");
    attempt(nc, 1'b0, "cfg_new_code");
    for (int j = CL - 1; j >= 0; j--) step(!nc[j], nc[j], 1'b1, RC);
    observe(0, 2, "cfg_in_entry_ignored");
    timeout_after(2, "cfg_timeout");
  endtask

  task automatic test_reset_mid();
    logic [CL-1:0] nc;
    nc = 5'b11100;
    step(1'b0, 1'b0, 1'b1, nc);
    m_code = nc;
    send_code(nc, 1'b0);
    for (int i = 0; i < 4; i++) idle_step();
    ncmp++; if (unlock !== 1'b1) begin nerr++; $display("FAIL mid_open_before got %b want 1", unlock); end
    #2 rst = 1'b0;
    #1;
    ncmp++; if ({unlock, busy, fail_cnt} !== 4'b0) begin nerr++; $display("FAIL mid_open_reset got %b want 0000", {unlock, busy, fail_cnt}); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_code = RC;
    m_fails = 0;
    attempt(RC, 1'b0, "reset_restores_code");
    for (int n = 0; n < MF - 1; n++) attempt(~RC, 1'b0, "mid_lock_pre");
    send_code(~RC, 1'b0);
    for (int i = 0; i < 13; i++) idle_step();
    ncmp++; if (locked_out !== 1'b1) begin nerr++; $display("FAIL mid_lock_before got %b want 1", locked_out); end
    #2 rst = 1'b0;
    #1;
    ncmp++; if ({locked_out, busy, fail_cnt} !== 4'b0) begin nerr++; $display("FAIL mid_lock_reset got %b want 0000", {locked_out, busy, fail_cnt}); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_code = RC;
    m_fails = 0;
    attempt(RC, 1'b0, "after_lock_reset");
  endtask

  task automatic test_random();
    logic [CL-1:0] v;
    int k;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      v = CL'($urandom);
      case (k)
        0: begin
          step(1'b0, 1'b0, 1'b1, v);
          m_code = v;
          attempt(m_code, 1'b0, "rnd_cfg");
        end
        1: attempt(m_code, 1'($urandom_range(0, 1)), "rnd_good");
        2: attempt(v, 1'($urandom_range(0, 1)), "rnd_any");
        3: invalid_at($urandom_range(0, CL - 1), "rnd_invalid");
        4: timeout_after($urandom_range(1, CL - 1), "rnd_timeout");
        default: attempt(m_code ^ (CL'(1) << $urandom_range(0, CL - 1)), 1'b0, "rnd_near");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_invalid();
    test_cfg();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
